// File: rtl/hello_char_sequencer.sv
// Paced character sequencer that feeds the "HELLO" scroll register chain.
// Emits one 3-bit character code per step with a load strobe and a 7-segment image.
module hello_char_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [2:0] char_code,
  output logic       shift_en,
  output logic       frame_done,
  output logic [6:0] seg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] CODE_H     = 3'd0;
  localparam logic [2:0] CODE_E     = 3'd1;
  localparam logic [2:0] CODE_L     = 3'd2;
  localparam logic [2:0] CODE_O     = 3'd3;
  localparam logic [2:0] CODE_BLANK = 3'd4;

  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_H  = 3'd1,
    S_E  = 3'd2,
    S_L1 = 3'd3,
    S_L2 = 3'd4,
    S_O  = 3'd5,
    S_B  = 3'd6
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       code_q,   code_d;
  logic [6:0]       seg_q,    seg_d;
  logic             shift_q,  shift_d;
  logic             frame_q,  frame_d;
  logic             step_c;

  // Word order; the blank step wraps back to H indefinitely.
  function automatic state_t next_state(input state_t s);
    state_t n;
    n = S_H;
    case (s)
      S_H:     n = S_E;
      S_E:     n = S_L1;
      S_L1:    n = S_L2;
      S_L2:    n = S_O;
      S_O:     n = S_B;
      S_B:     n = S_H;
      default: n = S_H;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] code_of(input state_t s);
    logic [2:0] c;
    c = CODE_BLANK;
    case (s)
      S_H:        c = CODE_H;
      S_E:        c = CODE_E;
      S_L1, S_L2: c = CODE_L;
      S_O:        c = CODE_O;
      default:    c = CODE_BLANK;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] seg_of(input logic [2:0] c);
    logic [6:0] g;
    g = SEG_BLANK;
    case (c)
      CODE_H:  g = SEG_H;
      CODE_E:  g = SEG_E;
      CODE_L:  g = SEG_L;
      CODE_O:  g = SEG_O;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Next-state, prescaler and output image; run==0 freezes everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    seg_d   = seg_q;
    shift_d = 1'b0;
    frame_d = 1'b0;
    step_c  = 1'b0;

    if (run) begin
      if (state_q == IDLE) begin
        state_d = S_H;
        cnt_d   = '0;
        step_c  = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        state_d = next_state(state_q);
        cnt_d   = '0;
        step_c  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (step_c) begin
      code_d  = code_of(state_d);
      seg_d   = seg_of(code_d);
      shift_d = 1'b1;
      frame_d = (state_d == S_B);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= CODE_BLANK;
      seg_q   <= SEG_BLANK;
      shift_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      seg_q   <= seg_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
    end
  end

  assign char_code  = code_q;
  assign seg        = seg_q;
  assign shift_en   = shift_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_hello_char_sequencer.sv
// Scoreboard bench for hello_char_sequencer: TICK_DIV=4 and TICK_DIV=1 instances
// share stimulus; a reference model queues expected outputs per cycle.
module tb_hello_char_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;

  logic [2:0] code4, code1;
  logic [6:0] seg4, seg1;
  logic       sh4, sh1, fr4, fr1;

  int n_vec  = 0;
  int n_miss = 0;

  hello_char_sequencer #(.TICK_DIV(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .reset(reset), .run(run),
    .char_code(code4), .shift_en(sh4), .frame_done(fr4), .seg(seg4)
  );

  hello_char_sequencer #(.TICK_DIV(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run),
    .char_code(code1), .shift_en(sh1), .frame_done(fr1), .seg(seg1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         idle;
    int         idx;
    int         cnt;
    logic [2:0] code;
    logic [6:0] seg;
    logic       sh;
    logic       fr;
  } mdl_t;

  int         word_code [6] = '{0, 1, 2, 2, 3, 4};
  logic [6:0] word_seg  [6] = '{7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F};

  mdl_t m4, m1;
  logic [23:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mstep(input mdl_t m, input bit rst_n, input bit go, input int div);
    mdl_t r;
    r = m;
    r.sh = 1'b0;
    r.fr = 1'b0;
    if (!rst_n) begin
      r.idle = 1'b1; r.idx = 0; r.cnt = 0;
      r.code = 3'd4; r.seg = 7'h7F;
    end else if (go) begin
      if (m.idle || m.cnt == div - 1) begin
        r.idx  = m.idle ? 0 : (m.idx + 1) % 6;
        r.idle = 1'b0;
        r.cnt  = 0;
        r.code = 3'(word_code[r.idx]);
        r.seg  = word_seg[r.idx];
        r.sh   = 1'b1;
        r.fr   = (r.idx == 5);
      end else begin
        r.cnt = m.cnt + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] pack(input mdl_t m);
    return {m.code, m.seg, m.sh, m.fr};
  endfunction

  // One clock: drive inputs, queue the expected post-edge outputs, then compare.
  task automatic cycle(input bit rst_n, input bit go, input string tag);
    logic [23:0] exp;
    reset = rst_n;
    run   = go;
    m4 = mstep(m4, rst_n, go, 4);
    m1 = mstep(m1, rst_n, go, 1);
    sb_q.push_back({pack(m4), pack(m1)});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check({tag, "/div4"}, 32'({code4, seg4, sh4, fr4}), 32'(exp[23:12]));
    check({tag, "/div1"}, 32'({code1, seg1, sh1, fr1}), 32'(exp[11:0]));
  endtask

  int pulses [$];
  int exp_pulse [7] = '{1, 5, 9, 13, 17, 21, 25};
  int exp_code  [7] = '{0, 1, 2, 2, 3, 4, 0};
  int codes_seen [$];
  int frame_at;
  int sh1_high;
  bit sh_seen;

  initial begin
    m4 = '{idle: 1'b1, idx: 0, cnt: 0, code: 3'd4, seg: 7'h7F, sh: 1'b0, fr: 1'b0};
    m1 = m4;

    // Reset, then idle with run low.
    cycle(0, 0, "rst");
    cycle(0, 0, "rst");
    check("rst_code", 32'(code4), 32'd4);
    check("rst_seg", 32'(seg4), 32'h7F);
    sh_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, "idle");
      if (sh4 || sh1) sh_seen = 1'b1;
    end
    check("idle_no_shift", 32'(sh_seen), 32'd0);
    check("idle_code", 32'(code4), 32'd4);

    // Run from IDLE: fixed pulse positions and frame marker.
    frame_at = -1;
    sh1_high = 0;
    for (int k = 1; k <= 26; k++) begin
      cycle(1, 1, $sformatf("run%0d", k));
      if (sh4) begin
        pulses.push_back(k);
        codes_seen.push_back(int'(code4));
      end
      if (fr4) frame_at = k;
      if (sh1) sh1_high++;
    end
    check("pulse_count", 32'(pulses.size()), 32'd7);
    for (int i = 0; i < 7 && i < pulses.size(); i++) begin
      check($sformatf("pulse_cyc%0d", i), 32'(pulses[i]), 32'(exp_pulse[i]));
      check($sformatf("pulse_code%0d", i), 32'(codes_seen[i]), 32'(exp_code[i]));
    end
    check("frame_cycle", 32'(frame_at), 32'd21);
    check("div1_always_high", 32'(sh1_high), 32'd26);

    // Pause after the E pulse; next pulse needs 4 run-high cycles in total.
    cycle(0, 0, "rst2");
    for (int k = 1; k <= 5; k++) cycle(1, 1, "pre_pause");
    check("pause_at_E", 32'(code4), 32'd1);
    sh_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, "pause");
      if (sh4) sh_seen = 1'b1;
    end
    check("pause_no_shift", 32'(sh_seen), 32'd0);
    check("pause_hold_code", 32'(code4), 32'd1);
    for (int k = 1; k <= 3; k++) cycle(1, 1, "resume");
    check("resume_not_yet", 32'(sh4), 32'd0);
    cycle(1, 1, "resume4");
    check("resume_shift", 32'(sh4), 32'd1);
    check("resume_code", 32'(code4), 32'd2);

    // Reset on the cycle the prescaler sits at 3 in S_O.
    cycle(0, 0, "rst3");
    for (int k = 1; k <= 20; k++) cycle(1, 1, "to_O");
    check("at_O", 32'(code4), 32'd3);
    cycle(0, 1, "mid_rst");
    check("mid_rst_shift", 32'(sh4), 32'd0);
    check("mid_rst_code", 32'(code4), 32'd4);
    check("mid_rst_seg", 32'(seg4), 32'h7F);
    cycle(1, 1, "post_rst");
    check("post_rst_shift", 32'(sh4), 32'd1);
    check("post_rst_code", 32'(code4), 32'd0);

    // Random run/reset mix against the model.
    for (int k = 0; k < 300; k++)
      cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
